// File: rtl/id_stage.sv
// Instruction-decode stage: one-entry pipeline register, opcode decode, RAW hazard stall.
// Define ID_FWD_EN to compile in the EX/WB bypass network (stage then never stalls).
module id_stage #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter int REG_AW = 2,
  localparam int IW = PC_W + 4 + 2 * REG_AW,
  localparam int OW = REG_AW + 4 + 2 * DATA_W + PC_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_to_ds_valid,
  input  logic [IW-1:0]     fs_to_ds_bus,
  output logic              ds_allowin,
  output logic [REG_AW-1:0] rx,
  output logic [REG_AW-1:0] ry,
  input  logic [DATA_W-1:0] rx_value,
  input  logic [DATA_W-1:0] ry_value,
  input  logic              es_we,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [DATA_W-1:0] es_value,
  input  logic              ws_we,
  input  logic [REG_AW-1:0] ws_dest,
  input  logic [DATA_W-1:0] ws_value,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [OW-1:0]     ds_to_es_bus
);

  logic              ds_valid;
  logic              ds_ready_go;
  logic [IW-1:0]     inst;
  logic [PC_W-1:0]   pc;
  logic [3:0]        op;
  logic [REG_AW-1:0] ry_addr;
  logic [REG_AW-1:0] rx_addr;
  logic [3:0]        op_oh;
  logic [DATA_W-1:0] rx_sel;
  logic [DATA_W-1:0] ry_sel;

  assign {pc, op, ry_addr, rx_addr} = inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      inst     <= '0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        inst <= fs_to_ds_bus;
      end
    end
  end

  always_comb begin
    op_oh = 4'b0000;
    unique case (1'b1)
      (op == 4'b0001): op_oh = 4'b1000;
      (op == 4'b0010): op_oh = 4'b0100;
      (op == 4'b0011): op_oh = 4'b0010;
      (op == 4'b0100): op_oh = 4'b0001;
      default:         op_oh = 4'b0000;
    endcase
  end

  assign rx = rx_addr;
  assign ry = ry_addr;

`ifdef ID_FWD_EN
  // ES is the younger write, so it is applied last and wins.
  always_comb begin
    rx_sel = rx_value;
    ry_sel = ry_value;
    if (ws_we && ws_dest == rx_addr) rx_sel = ws_value;
    if (ws_we && ws_dest == ry_addr) ry_sel = ws_value;
    if (es_we && es_dest == rx_addr) rx_sel = es_value;
    if (es_we && es_dest == ry_addr) ry_sel = es_value;
  end

  assign ds_ready_go = 1'b1;
`else
  logic rd_rx;
  logic rd_ry;
  logic rx_hit;
  logic ry_hit;
  logic unused_fwd;

  // move reads only ry; add/sub/and read both; NOPs read nothing.
  assign rd_ry = |op_oh;
  assign rd_rx = |op_oh[2:0];

  assign rx_hit = rd_rx &&
    ((es_we && es_dest == rx_addr) || (ws_we && ws_dest == rx_addr));
  assign ry_hit = rd_ry &&
    ((es_we && es_dest == ry_addr) || (ws_we && ws_dest == ry_addr));

  assign ds_ready_go = !(rx_hit || ry_hit);
  assign rx_sel      = rx_value;
  assign ry_sel      = ry_value;
  assign unused_fwd  = ^{es_value, ws_value};
`endif

  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  assign ds_to_es_bus   = {rx_addr, op_oh, ry_sel, rx_sel, pc};

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table, directed corner cases, random vs model.
// Directed RAW checks follow ID_FWD_EN when it is defined.
module tb_id_stage;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int AW = 2;
  localparam int IW = PW + 4 + 2 * AW;
  localparam int OW = AW + 4 + 2 * DW + PW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fs_to_ds_valid;
  logic [IW-1:0] fs_to_ds_bus;
  logic          ds_allowin;
  logic [AW-1:0] rx, ry;
  logic [DW-1:0] rx_value, ry_value;
  logic          es_we, ws_we;
  logic [AW-1:0] es_dest, ws_dest;
  logic [DW-1:0] es_value, ws_value;
  logic          es_allowin;
  logic          ds_to_es_valid;
  logic [OW-1:0] ds_to_es_bus;

  logic [DW-1:0] regs [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rx_value = regs[rx];
  assign ry_value = regs[ry];

  id_stage #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .rx(rx), .ry(ry),
    .rx_value(rx_value), .ry_value(ry_value),
    .es_we(es_we), .es_dest(es_dest), .es_value(es_value),
    .ws_we(ws_we), .ws_dest(ws_dest), .ws_value(ws_value),
    .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [7:0] pc,
    input logic [3:0] op, input logic [1:0] rya, input logic [1:0] rxa);
    return {pc, op, rya, rxa};
  endfunction

  function automatic logic [OW-1:0] eb(input logic [1:0] dest,
    input logic [3:0] oh, input logic [7:0] ryv, input logic [7:0] rxv,
    input logic [7:0] pc);
    return {dest, oh, ryv, rxv, pc};
  endfunction

  // Reference model helpers
  function automatic logic [3:0] ref_oh(input logic [3:0] op);
    case (op)
      4'd1: return 4'b1000;
      4'd2: return 4'b0100;
      4'd3: return 4'b0010;
      4'd4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit hz(input logic [1:0] a);
    return (es_we && es_dest == a) || (ws_we && ws_dest == a);
  endfunction

  function automatic logic [7:0] opnd(input logic [1:0] a);
`ifdef ID_FWD_EN
    if (es_we && es_dest == a) return es_value;
    if (ws_we && ws_dest == a) return ws_value;
`endif
    return regs[a];
  endfunction

  typedef struct {
    logic          fv;
    logic [IW-1:0] bus;
    logic          ea;
    logic          ev;
    logic          ew;
    logic [OW-1:0] eb;
  } vec_t;

  vec_t tbl[11];

  logic          m_full;
  logic [IW-1:0] m_inst;
  logic [3:0]    m_op;
  logic [1:0]    m_rxa, m_rya;
  bit            m_stall, e_valid, e_allow;

  initial begin
    regs[0] = 8'h11; regs[1] = 8'h07; regs[2] = 8'h05; regs[3] = 8'h33;
    resetn = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h55, 4'b0010, 2'd3, 2'd3);
    es_allowin = 1'b1;
    es_we = 1'b0; es_dest = '0; es_value = '0;
    ws_we = 1'b0; ws_dest = '0; ws_value = '0;

    tbl[0]  = '{1, mk(8'h10, 4'b0010, 1, 2), 1, 0, 1, '0};
    tbl[1]  = '{1, mk(8'h20, 4'b0001, 3, 0), 1, 1, 1,
                eb(2, 4'b0100, 8'h07, 8'h05, 8'h10)};
    tbl[2]  = '{1, mk(8'h21, 4'b0010, 0, 1), 1, 1, 1,
                eb(0, 4'b1000, 8'h33, 8'h11, 8'h20)};
    tbl[3]  = '{1, mk(8'h22, 4'b0011, 2, 3), 1, 1, 1,
                eb(1, 4'b0100, 8'h11, 8'h07, 8'h21)};
    tbl[4]  = '{1, mk(8'h23, 4'b0100, 1, 0), 1, 1, 1,
                eb(3, 4'b0010, 8'h05, 8'h33, 8'h22)};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{1, mk(8'h24, 4'b1111, 2, 1), 0, 1, 0,
                 eb(0, 4'b0001, 8'h07, 8'h11, 8'h23)};
    tbl[8]  = '{1, mk(8'h24, 4'b1111, 2, 1), 1, 1, 1,
                eb(0, 4'b0001, 8'h07, 8'h11, 8'h23)};
    tbl[9]  = '{0, '0, 1, 1, 1, eb(1, 4'b0000, 8'h05, 8'h07, 8'h24)};
    tbl[10] = '{0, '0, 1, 0, 1, '0};

    // Reset with IF offering an instruction
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ds_to_es_valid, 0);
    chk("rst_allowin", ds_allowin, 1);
    chk("rst_rx", rx, 0);
    chk("rst_ry", ry, 0);
    chk("rst_op", ds_to_es_bus[27:24], 0);
    resetn = 1'b1;
    fs_to_ds_valid = 1'b0;

    // Stream, illegal opcode, backpressure
    for (int i = 0; i < 11; i++) begin
      step();
      fs_to_ds_valid = tbl[i].fv;
      fs_to_ds_bus = tbl[i].bus;
      es_allowin = tbl[i].ea;
      #4;
      chk($sformatf("tbl%0d_valid", i), ds_to_es_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_allowin", i), ds_allowin, tbl[i].ew);
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_bus", i), ds_to_es_bus, tbl[i].eb);
    end

    // RAW against EX then WB
    step();
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h30, 4'b0010, 0, 1);
    step();
    fs_to_ds_valid = 1'b0;
    es_we = 1'b1; es_dest = 2'd1; es_value = 8'hAA;
    ws_we = 1'b0; ws_dest = 2'd1; ws_value = 8'hBB;
`ifndef ID_FWD_EN
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("raw_es_valid%0d", k), ds_to_es_valid, 0);
      chk($sformatf("raw_es_allowin%0d", k), ds_allowin, 0);
      step();
    end
    es_we = 1'b0;
    #4;
    chk("raw_es_release", ds_to_es_valid, 1);
    chk("raw_es_bus", ds_to_es_bus, eb(1, 4'b0100, 8'h11, 8'h07, 8'h30));
    step();
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h31, 4'b0001, 3, 0);
    step();
    fs_to_ds_valid = 1'b0;
    ws_we = 1'b1; ws_dest = 2'd3;
    #4;
    chk("raw_ws_stall", ds_to_es_valid, 0);
    step();
    ws_we = 1'b0;
    #4;
    chk("raw_ws_release", ds_to_es_valid, 1);
    chk("raw_ws_bus", ds_to_es_bus, eb(0, 4'b1000, 8'h33, 8'h11, 8'h31));
`else
    ws_we = 1'b1;
    regs[1] = 8'h00;
    es_allowin = 1'b0;
    #4;
    chk("fwd_valid", ds_to_es_valid, 1);
    chk("fwd_es_field", ds_to_es_bus[15:8], 8'hAA);
    step();
    es_we = 1'b0;
    #4;
    chk("fwd_ws_field", ds_to_es_bus[15:8], 8'hBB);
    step();
    es_allowin = 1'b1;
    ws_we = 1'b0;
    regs[1] = 8'h07;
`endif
    step();
    #4;
    chk("raw_drain", ds_to_es_valid, 0);

    // NOP never hazards
    step();
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h40, 4'b1111, 1, 1);
    step();
    fs_to_ds_valid = 1'b0;
    es_we = 1'b1; es_dest = 2'd1;
    #4;
    chk("nop_valid", ds_to_es_valid, 1);
    chk("nop_allowin", ds_allowin, 1);
    step();
    es_we = 1'b0;
    #4;
    chk("nop_drain", ds_to_es_valid, 0);

    // Reset while stalled
    step();
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h50, 4'b0010, 2, 3);
    es_allowin = 1'b0;
    step();
    fs_to_ds_valid = 1'b0;
    #4;
    chk("mid_held", ds_allowin, 0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", ds_to_es_valid, 0);
    chk("mid_rst_allowin", ds_allowin, 1);
    chk("mid_rst_rxry", {ry, rx}, 0);
    step();
    resetn = 1'b1;
    es_allowin = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = mk(8'h51, 4'b0100, 1, 2);
    step();
    fs_to_ds_valid = 1'b0;
    #4;
    chk("mid_new_valid", ds_to_es_valid, 1);
    chk("mid_new_bus", ds_to_es_bus, eb(2, 4'b0001, 8'h07, 8'h05, 8'h51));

    // Random traffic against the model
    for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
    m_full = 1'b0;
    m_inst = '0;
    for (int n = 0; n < 600; n++) begin
      step();
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      fs_to_ds_bus = IW'($urandom);
      es_allowin = ($urandom_range(0, 3) != 0);
      es_we = ($urandom_range(0, 2) == 0);
      es_dest = AW'($urandom);
      es_value = DW'($urandom);
      ws_we = ($urandom_range(0, 2) == 0);
      ws_dest = AW'($urandom);
      ws_value = DW'($urandom);
      #4;
      m_rxa = m_inst[1:0];
      m_rya = m_inst[3:2];
      m_op = m_inst[7:4];
`ifdef ID_FWD_EN
      m_stall = 1'b0;
`else
      m_stall = (m_op >= 4'd2 && m_op <= 4'd4 && hz(m_rxa)) ||
                (m_op >= 4'd1 && m_op <= 4'd4 && hz(m_rya));
`endif
      e_valid = m_full && !m_stall;
      e_allow = !m_full || (!m_stall && es_allowin);
      chk("rnd_valid", ds_to_es_valid, e_valid);
      chk("rnd_allowin", ds_allowin, e_allow);
      if (m_full) chk("rnd_rxry", {ry, rx}, {m_rya, m_rxa});
      if (e_valid)
        chk("rnd_bus", ds_to_es_bus,
            eb(m_rxa, ref_oh(m_op), opnd(m_rya), opnd(m_rxa), m_inst[15:8]));
      if (e_allow) begin
        m_full = fs_to_ds_valid;
        if (fs_to_ds_valid) m_inst = fs_to_ds_bus;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
